hilo_muldiv_ctrl: RTL and testbench

Iterative signed multiply/divide sequencer for the multicycle MIPS datapath. It accepts a MULT or DIV request from the main control unit with operands taken from registers A and B. It runs a fixed-length shift-add or restoring-divide sequence, then issues a single write pulse with the 64-bit result destined for the HI and LO registers. It owns the multi-cycle timing of HI/LO updates so the control unit only needs a start/done handshake.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_step.sv | 61 ++++++
 rtl/hilo_muldiv_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: FSM state
// encoding, operation codes and the default operand width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply/divide datapath, working on
// magnitudes only.
//   MULT: {hi_acc, lo_acc} is the shift-add product register. lo_acc holds the
//         remaining multiplier bits. oper is the multiplicand magnitude.
//   DIV : hi_acc is the partial remainder. lo_acc shifts the dividend out and
//         the quotient in. oper is the divisor magnitude.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH:0]   hi_acc,
    input  logic [WIDTH-1:0] lo_acc,
    input  logic [WIDTH:0]   oper,
    output logic [WIDTH:0]   hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH+1:0] add_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] trial_s;

    // Single shift-add or restoring-divide step selected by op
    always_comb begin
        add_s   = {(WIDTH+2){1'b0}};
        shift_s = {(WIDTH+1){1'b0}};
        trial_s = {(WIDTH+2){1'b0}};
        hi_next = hi_acc;
        lo_next = lo_acc;
        case (op)
            OP_MULT: begin
                // Conditionally add the multiplicand, then shift the pair right
                if (lo_acc[0]) begin
                    add_s = {1'b0, hi_acc} + {1'b0, oper};
                end else begin
                    add_s = {1'b0, hi_acc};
                end
                hi_next = add_s[WIDTH+1:1];
                lo_next = {add_s[0], lo_acc[WIDTH-1:1]};
            end
            OP_DIV: begin
                // Shift in the next dividend bit and try subtracting the divisor
                shift_s = {hi_acc[WIDTH-1:0], lo_acc[WIDTH-1]};
                trial_s = {1'b0, shift_s} - {1'b0, oper};
                if (!trial_s[WIDTH+1]) begin
                    hi_next = trial_s[WIDTH:0];
                    lo_next = {lo_acc[WIDTH-2:0], 1'b1};
                end else begin
                    hi_next = shift_s;
                    lo_next = {lo_acc[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                hi_next = hi_acc;
                lo_next = lo_acc;
            end
        endcase
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative signed MULT/DIV sequencer that produces the 64-bit HI/LO result
// behind a start/done handshake. Operands are converted to WIDTH+1-bit
// magnitudes. WIDTH iterations run in RUN, signs are applied in FIX, and DONE
// issues a single-cycle done/hilo_write strobe.
// Optional feature macro: MULTDIV_DIVZERO_EXC_EN. When it is defined, DIV by
// zero skips the sequence and raises div_zero with done and no HI/LO write.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic             hilo_write,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state_r, state_s;

    logic [CNT_W-1:0]   cnt_r;
    logic               op_r;
    logic               neg_res_r;
    logic               neg_rem_r;
    logic [WIDTH:0]     hi_acc_r;
    logic [WIDTH-1:0]   lo_acc_r;
    logic [WIDTH:0]     oper_r;
    logic [WIDTH:0]     hi_step_s;
    logic [WIDTH-1:0]   lo_step_s;
    logic [WIDTH:0]     mag_a_s;
    logic [WIDTH:0]     mag_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   hi_fix_s;
    logic [WIDTH-1:0]   lo_fix_s;
    logic               dz_detect_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;
    logic               hilo_write_nxt_s;
    logic               div_zero_nxt_s;
    logic               busy_r;
    logic               done_r;
    logic               hilo_write_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_out_r;
    logic [WIDTH-1:0]   lo_out_r;

    // Magnitude of a signed operand; WIDTH+1 bits so the most negative value fits
    function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = -{1'b1, v};
        end else begin
            magnitude = {1'b0, v};
        end
    endfunction

`ifdef MULTDIV_DIVZERO_EXC_EN
    assign dz_detect_s = (op == OP_DIV) && (opb == {WIDTH{1'b0}});
`else
    assign dz_detect_s = 1'b0;
`endif

    assign mag_a_s = magnitude(opa);
    assign mag_b_s = magnitude(opb);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_r),
        .hi_acc  (hi_acc_r),
        .lo_acc  (lo_acc_r),
        .oper    (oper_r),
        .hi_next (hi_step_s),
        .lo_next (lo_step_s)
    );

    // Next-state logic and next values of the registered status outputs
    always_comb begin
        state_s          = state_r;
        done_nxt_s       = 1'b0;
        hilo_write_nxt_s = 1'b0;
        div_zero_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (dz_detect_s) begin
                        state_s        = DONE;
                        done_nxt_s     = 1'b1;
                        div_zero_nxt_s = 1'b1;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX: begin
                state_s          = DONE;
                done_nxt_s       = 1'b1;
                hilo_write_nxt_s = 1'b1;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_s != IDLE);
    end

    // Sign correction of the finished magnitudes (truncating division)
    always_comb begin
        prod_s   = {hi_acc_r[WIDTH-1:0], lo_acc_r};
        rem_s    = hi_acc_r[WIDTH-1:0];
        hi_fix_s = {WIDTH{1'b0}};
        lo_fix_s = {WIDTH{1'b0}};
        if (op_r == OP_DIV) begin
            if (neg_res_r) begin
                lo_fix_s = -lo_acc_r;
            end else begin
                lo_fix_s = lo_acc_r;
            end
            if (neg_rem_r) begin
                hi_fix_s = -rem_s;
            end else begin
                hi_fix_s = rem_s;
            end
        end else begin
            if (neg_res_r) begin
                prod_s = -{hi_acc_r[WIDTH-1:0], lo_acc_r};
            end else begin
                prod_s = {hi_acc_r[WIDTH-1:0], lo_acc_r};
            end
            hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
            lo_fix_s = prod_s[WIDTH-1:0];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, iteration counter and working registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= OP_MULT;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_acc_r  <= {(WIDTH+1){1'b0}};
            lo_acc_r  <= {WIDTH{1'b0}};
            oper_r    <= {(WIDTH+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r      <= op;
                        cnt_r     <= {CNT_W{1'b0}};
                        hi_acc_r  <= {(WIDTH+1){1'b0}};
                        neg_res_r <= opa[WIDTH-1] ^ opb[WIDTH-1];
                        neg_rem_r <= opa[WIDTH-1];
                        if (op == OP_DIV) begin
                            lo_acc_r <= mag_a_s[WIDTH-1:0];
                            oper_r   <= mag_b_s;
                        end else begin
                            lo_acc_r <= mag_b_s[WIDTH-1:0];
                            oper_r   <= mag_a_s;
                        end
                    end
                end
                RUN: begin
                    hi_acc_r <= hi_step_s;
                    lo_acc_r <= lo_step_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered status strobes and HI/LO result (updated only in FIX)
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            hilo_write_r <= 1'b0;
            div_zero_r   <= 1'b0;
            hi_out_r     <= {WIDTH{1'b0}};
            lo_out_r     <= {WIDTH{1'b0}};
        end else begin
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            hilo_write_r <= hilo_write_nxt_s;
            div_zero_r   <= div_zero_nxt_s;
            if (state_r == FIX) begin
                hi_out_r <= hi_fix_s;
                lo_out_r <= lo_fix_s;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign hilo_write = hilo_write_r;
    assign div_zero   = div_zero_r;
    assign hi_out     = hi_out_r;
    assign lo_out     = lo_out_r;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed self-checking bench for hilo_muldiv_ctrl. Divide-by-zero
// expectations follow MULTDIV_DIVZERO_EXC_EN.
module tb_hilo_muldiv_ctrl;

    localparam int WIN = 75;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        done;
    logic        hilo_write;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        div_zero;

    int n_cmp;
    int n_bad;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .hilo_write (hilo_write),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, sampled at E0; observe WIN cycles on falling edges.
    // n counts cycles after E0. Extra start pulses are raised at n == inj_a/inj_b
    // so that they are sampled at edge E(n+1).
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input int inj_a, input int inj_b,
                          output int lat, output int ndone, output int nhw,
                          output int blow, output logic dzf,
                          output logic [31:0] hi, output logic [31:0] lo);
        lat = -1; ndone = 0; nhw = 0; blow = -1; dzf = 1'b0; hi = 32'h0; lo = 32'h0;
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        for (int n = 0; n < WIN; n++) begin
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = n; dzf = div_zero; hi = hi_out; lo = lo_out;
                end
            end
            if (hilo_write === 1'b1) nhw++;
            if (busy === 1'b0 && blow < 0) blow = n;
            start = (n == inj_a || n == inj_b);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 1'b0; opa = 32'h0; opb = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (hilo_write !== 1'b0) begin n_bad++; $display("FAIL reset_hw: got %b expected 0", hilo_write); end
        n_cmp++; if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
        n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h expected 0", hi_out); end
        n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h expected 0", lo_out); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int lat, nd, nhw, bl; logic dzf; logic [31:0] hi, lo;
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, -1, -1, lat, nd, nhw, bl, dzf, hi, lo);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mult_latency: got %0d expected 33", lat); end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL mult_done_count: got %0d expected 1", nd); end
        n_cmp++; if (nhw !== 1) begin n_bad++; $display("FAIL mult_hw_count: got %0d expected 1", nhw); end
        n_cmp++; if (bl !== 34) begin n_bad++; $display("FAIL mult_busy_drop: got %0d expected 34", bl); end
        n_cmp++; if (dzf !== 1'b0) begin n_bad++; $display("FAIL mult_dz: got %b expected 0", dzf); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo); end
        run_op(1'b0, 32'h80000000, 32'h80000000, -1, -1, lat, nd, nhw, bl, dzf, hi, lo);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mult_min_latency: got %0d expected 33", lat); end
        n_cmp++; if (hi !== 32'h40000000) begin n_bad++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
        n_cmp++; if (lo !== 32'h00000000) begin n_bad++; $display("FAIL mult_min_lo: got %h expected 00000000", lo); end
    endtask

    task automatic test_div();
        int lat, nd, nhw, bl; logic dzf; logic [31:0] hi, lo;
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, -1, -1, lat, nd, nhw, bl, dzf, hi, lo);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL div_latency: got %0d expected 33", lat); end
        n_cmp++; if (nhw !== 1) begin n_bad++; $display("FAIL div_hw_count: got %0d expected 1", nhw); end
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, -1, lat, nd, nhw, bl, dzf, hi, lo);
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL div_wrap_lo: got %h expected 80000000", lo); end
        n_cmp++; if (hi !== 32'h00000000) begin n_bad++; $display("FAIL div_wrap_hi: got %h expected 00000000", hi); end
        n_cmp++; if (dzf !== 1'b0) begin n_bad++; $display("FAIL div_wrap_dz: got %b expected 0", dzf); end
    endtask

    // Runs directly after test_div, so the held result is HI=0, LO=0x80000000
    task automatic test_div_zero();
        int lat, nd, nhw, bl; logic dzf; logic [31:0] hi, lo;
        run_op(1'b1, 32'd5, 32'd0, -1, -1, lat, nd, nhw, bl, dzf, hi, lo);
`ifdef MULTDIV_DIVZERO_EXC_EN
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL dz_latency: got %0d expected 0", lat); end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL dz_done_count: got %0d expected 1", nd); end
        n_cmp++; if (dzf !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b expected 1", dzf); end
        n_cmp++; if (nhw !== 0) begin n_bad++; $display("FAIL dz_hw_count: got %0d expected 0", nhw); end
        n_cmp++; if (bl !== 1) begin n_bad++; $display("FAIL dz_busy_drop: got %0d expected 1", bl); end
        n_cmp++; if (hi !== 32'h00000000) begin n_bad++; $display("FAIL dz_hi_held: got %h expected 00000000", hi); end
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL dz_lo_held: got %h expected 80000000", lo); end
`else
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL dz_latency: got %0d expected 33", lat); end
        n_cmp++; if (nhw !== 1) begin n_bad++; $display("FAIL dz_hw_count: got %0d expected 1", nhw); end
        n_cmp++; if (dzf !== 1'b0) begin n_bad++; $display("FAIL dz_flag: got %b expected 0", dzf); end
        n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL dz_pos_hi: got %h expected 00000005", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL dz_pos_lo: got %h expected ffffffff", lo); end
        run_op(1'b1, 32'hFFFFFFFB, 32'd0, -1, -1, lat, nd, nhw, bl, dzf, hi, lo);
        n_cmp++; if (hi !== 32'hFFFFFFFB) begin n_bad++; $display("FAIL dz_neg_hi: got %h expected fffffffb", hi); end
        n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL dz_neg_lo: got %h expected 00000001", lo); end
`endif
    endtask

    // Extra start pulses at E10 (RUN) and E34 (DONE cycle) must be dropped
    task automatic test_ignored_start();
        int lat, nd, nhw, bl; logic dzf; logic [31:0] hi, lo;
        run_op(1'b0, 32'h12345678, 32'h00000010, 9, 33, lat, nd, nhw, bl, dzf, hi, lo);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL ign_latency: got %0d expected 33", lat); end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL ign_done_count: got %0d expected 1", nd); end
        n_cmp++; if (nhw !== 1) begin n_bad++; $display("FAIL ign_hw_count: got %0d expected 1", nhw); end
        n_cmp++; if (hi !== 32'h00000001) begin n_bad++; $display("FAIL ign_hi: got %h expected 00000001", hi); end
        n_cmp++; if (lo !== 32'h23456780) begin n_bad++; $display("FAIL ign_lo: got %h expected 23456780", lo); end
    endtask

    task automatic test_reset_mid();
        int lat, nd, nhw, bl; logic dzf; logic [31:0] hi, lo;
        int ndone_after;
        @(negedge clk);
        op = 1'b0; opa = 32'h12345678; opb = 32'h00000009; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmid_done: got %b expected 0", done); end
        n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL rmid_hi: got %h expected 0", hi_out); end
        n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL rmid_lo: got %h expected 0", lo_out); end
        reset = 1'b1;
        ndone_after = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || hilo_write === 1'b1) ndone_after++;
        end
        n_cmp++; if (ndone_after !== 0) begin n_bad++; $display("FAIL rmid_stray_done: got %0d expected 0", ndone_after); end
        run_op(1'b0, 32'd3, 32'd4, -1, -1, lat, nd, nhw, bl, dzf, hi, lo);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL rmid_next_latency: got %0d expected 33", lat); end
        n_cmp++; if (lo !== 32'd12) begin n_bad++; $display("FAIL rmid_next_lo: got %h expected 0000000c", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL rmid_next_hi: got %h expected 00000000", hi); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
